// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, arbiter state encoding and the leading-zero blanking helper.
// The helper is only called when SEG7_LEADING_BLANK_EN is defined.
package seg7_pkg;

    localparam logic [3:0] SEG7_CODE_MINUS = 4'd10;
    localparam logic [3:0] SEG7_CODE_BLANK = 4'd15;

    // Segment order {dp,g,f,e,d,c,b,a}, active-high
    localparam logic [7:0] SEG7_PAT_0     = 8'h3F;
    localparam logic [7:0] SEG7_PAT_1     = 8'h06;
    localparam logic [7:0] SEG7_PAT_2     = 8'h5B;
    localparam logic [7:0] SEG7_PAT_3     = 8'h4F;
    localparam logic [7:0] SEG7_PAT_4     = 8'h66;
    localparam logic [7:0] SEG7_PAT_5     = 8'h6D;
    localparam logic [7:0] SEG7_PAT_6     = 8'h7D;
    localparam logic [7:0] SEG7_PAT_7     = 8'h07;
    localparam logic [7:0] SEG7_PAT_8     = 8'h7F;
    localparam logic [7:0] SEG7_PAT_9     = 8'h6F;
    localparam logic [7:0] SEG7_PAT_MINUS = 8'h40;
    localparam logic [7:0] SEG7_PAT_OFF   = 8'h00;

    // State value doubles as the one-hot grant vector
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_OWN0 = 2'b01,
        ARB_OWN1 = 2'b10
    } arb_state_t;

    // Walk from digit 3 down: zeros are blanked while only zeros/blank codes sit above.
    function automatic logic [15:0] seg7_blank_leading(input logic [15:0] d);
        logic [15:0] r;
        logic        sup;
        logic [3:0]  c;
        r   = d;
        sup = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            c = d[4*i +: 4];
            if (sup && c == 4'd0) begin
                r[4*i +: 4] = SEG7_CODE_BLANK;
            end else if (c >= 4'd1 && c <= SEG7_CODE_MINUS) begin
                sup = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit display code to segment pattern: 0..9 digits, 10 minus, 11..15 blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] pat
);

    always_comb begin
        pat = SEG7_PAT_OFF;
        case (code)
            4'd0:  pat = SEG7_PAT_0;
            4'd1:  pat = SEG7_PAT_1;
            4'd2:  pat = SEG7_PAT_2;
            4'd3:  pat = SEG7_PAT_3;
            4'd4:  pat = SEG7_PAT_4;
            4'd5:  pat = SEG7_PAT_5;
            4'd6:  pat = SEG7_PAT_6;
            4'd7:  pat = SEG7_PAT_7;
            4'd8:  pat = SEG7_PAT_8;
            4'd9:  pat = SEG7_PAT_9;
            SEG7_CODE_MINUS: pat = SEG7_PAT_MINUS;
            default: pat = SEG7_PAT_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_arbiter.sv
// Two-requester arbiter for the 4-digit multiplexed display; ownership only changes at frame ends.
// Optional SEG7_LEADING_BLANK_EN blanks leading zeros when the shadow register is loaded.
module seg7_scan_arbiter
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int DIV_W       = 17,
    parameter int HOLD_FRAMES = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [15:0] digits0,
    input  logic [15:0] digits1,
    output logic [1:0]  grant,
    output logic [7:0]  seg7,
    output logic [3:0]  seg7_sel
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       HOLD_LIM = 8'(HOLD_FRAMES);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       scan_idx;
    logic             boundary;

    arb_state_t  state, state_nxt;
    logic        last_owner, last_owner_nxt;
    logic [7:0]  frames_held, frames_held_nxt;
    logic [15:0] shadow, shadow_nxt;

    logic        owner_idx;
    logic        owner_req;
    logic        other_req;
    logic        winner;
    logic [15:0] load_digits;
    logic [3:0]  cur_code;
    logic [7:0]  cur_pat;

    assign tick     = (div_cnt == DIV_LAST);
    assign boundary = tick && (scan_idx == 2'd3);
    assign grant    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign cur_code = shadow[{scan_idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .code (cur_code),
        .pat  (cur_pat)
    );

    // Digit 3 of the outgoing frame is shown from the old shadow on the boundary edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx <= 2'd0;
            seg7     <= SEG7_PAT_OFF;
            seg7_sel <= 4'b0000;
        end else if (tick) begin
            scan_idx <= scan_idx + 2'd1;
            seg7     <= cur_pat;
            seg7_sel <= 4'b0001 << scan_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            last_owner  <= 1'b1;
            frames_held <= 8'd0;
            shadow      <= {4{SEG7_CODE_BLANK}};
        end else begin
            state       <= state_nxt;
            last_owner  <= last_owner_nxt;
            frames_held <= frames_held_nxt;
            shadow      <= shadow_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        last_owner_nxt  = last_owner;
        frames_held_nxt = frames_held;
        shadow_nxt      = shadow;
        owner_idx       = (state == ARB_OWN1);
        owner_req       = (state != ARB_IDLE) && req[owner_idx];
        other_req       = (state != ARB_IDLE) && req[~owner_idx];
        winner          = req[~last_owner] ? ~last_owner : last_owner;
        load_digits     = digits0;

        if (boundary) begin
            if (owner_req && (!other_req || frames_held < HOLD_LIM)) begin
                load_digits     = owner_idx ? digits1 : digits0;
                frames_held_nxt = (frames_held == 8'hFF) ? 8'hFF : frames_held + 8'd1;
                shadow_nxt      = load_digits;
            end else if (|req) begin
                load_digits     = winner ? digits1 : digits0;
                state_nxt       = winner ? ARB_OWN1 : ARB_OWN0;
                last_owner_nxt  = winner;
                frames_held_nxt = 8'd0;
                shadow_nxt      = load_digits;
            end else begin
                state_nxt  = ARB_IDLE;
                shadow_nxt = {4{SEG7_CODE_BLANK}};
            end
`ifdef SEG7_LEADING_BLANK_EN
            if (state_nxt != ARB_IDLE) begin
                shadow_nxt = seg7_blank_leading(load_digits);
            end
`endif
        end
    end

endmodule

// File: tb/tb_seg7_scan_arbiter.sv
// Randomized bench for seg7_scan_arbiter against a frame-level reference model.
module tb_seg7_scan_arbiter;

    localparam int SCAN_DIV    = 4;
    localparam int DIV_W       = 2;
    localparam int HOLD_FRAMES = 2;
    localparam int FRAME_CYC   = 4 * SCAN_DIV;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] digits0;
    logic [15:0] digits1;
    logic [1:0]  grant;
    logic [7:0]  seg7;
    logic [3:0]  seg7_sel;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    seg7_scan_arbiter #(
        .SCAN_DIV    (SCAN_DIV),
        .DIV_W       (DIV_W),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .digits0  (digits0),
        .digits1  (digits1),
        .grant    (grant),
        .seg7     (seg7),
        .seg7_sel (seg7_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: counts cycles and ticks since reset, applies arbitration rules per frame
    logic [7:0] pat_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int         m_cyc;
    int         m_ticks;
    int         m_owner;
    int         m_last;
    int         m_held;
    int         m_shadow [4];
    logic [7:0] m_seg;
    logic [3:0] m_sel;

    task automatic model_reset();
        m_cyc   = 0;
        m_ticks = 0;
        m_owner = -1;
        m_last  = 1;
        m_held  = 0;
        for (int i = 0; i < 4; i++) m_shadow[i] = 15;
        m_seg = 8'h00;
        m_sel = 4'b0000;
    endtask

    task automatic model_load(input int who);
        logic [15:0] d;
        bit          hi_clear;
        d = (who == 1) ? digits1 : digits0;
        for (int i = 0; i < 4; i++) m_shadow[i] = int'(d[4*i +: 4]);
`ifdef SEG7_LEADING_BLANK_EN
        for (int i = 1; i < 4; i++) begin
            hi_clear = 1;
            for (int j = i + 1; j < 4; j++)
                if (int'(d[4*j +: 4]) >= 1 && int'(d[4*j +: 4]) <= 10) hi_clear = 0;
            if (d[4*i +: 4] == 4'd0 && hi_clear) m_shadow[i] = 15;
        end
`else
        hi_clear = 0;
`endif
    endtask

    task automatic model_frame_end();
        bit owner_wants;
        bit other_wants;
        int w;
        owner_wants = (m_owner >= 0) && req[m_owner];
        other_wants = (m_owner >= 0) && req[1 - m_owner];
        if (owner_wants && (!other_wants || m_held < HOLD_FRAMES)) begin
            m_held = (m_held >= 255) ? 255 : m_held + 1;
            model_load(m_owner);
        end else if (req != 2'b00) begin
            w       = req[1 - m_last] ? 1 - m_last : m_last;
            m_owner = w;
            m_last  = w;
            m_held  = 0;
            model_load(w);
        end else begin
            m_owner = -1;
            for (int i = 0; i < 4; i++) m_shadow[i] = 15;
        end
    endtask

    task automatic model_edge();
        int d;
        if (m_cyc % SCAN_DIV == SCAN_DIV - 1) begin
            d     = m_ticks % 4;
            m_sel = 4'(1 << d);
            m_seg = pat_tab[m_shadow[d]];
            if (d == 3) model_frame_end();
            m_ticks++;
        end
        m_cyc++;
    endtask

    function automatic logic [1:0] exp_grant();
        return (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    always begin
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        if (chk_en) begin
            check("grant", {14'd0, grant}, {14'd0, exp_grant()});
            check("seg7", {8'd0, seg7}, {8'd0, m_seg});
            check("seg7_sel", {12'd0, seg7_sel}, {12'd0, m_sel});
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        d = 16'($urandom_range(0, 65535));
        case ($urandom_range(0, 3))
            0: d[15:12] = 4'd0;
            1: d[15:8]  = 8'd0;
            2: d[15:4]  = 12'd0;
            default: ;
        endcase
        return d;
    endfunction

    initial begin
        rst_n   = 1'b0;
        req     = 2'b00;
        digits0 = 16'h0000;
        digits1 = 16'h0000;
        model_reset();
        run_cycles(3);
        check("reset_seg7", {8'd0, seg7}, 16'h0000);
        check("reset_sel", {12'd0, seg7_sel}, 16'h0000);
        check("reset_grant", {14'd0, grant}, 16'h0000);
        chk_en = 1;
        rst_n  = 1'b1;

        // idle, first tick
        run_cycles(8);
        // single requester showing 1234
        req     = 2'b01;
        digits0 = 16'h1234;
        run_cycles(3 * FRAME_CYC);
        // both requesting, hold/rotate
        req     = 2'b11;
        digits1 = 16'h9876;
        run_cycles(12 * FRAME_CYC);
        // owner drops mid-frame, other idle
        run_cycles(FRAME_CYC / 2);
        req = 2'b00;
        run_cycles(3 * FRAME_CYC);
        // blank / minus codes
        req     = 2'b01;
        digits0 = 16'hA05F;
        run_cycles(3 * FRAME_CYC);
        // leading zeros
        digits0 = 16'h0007;
        run_cycles(3 * FRAME_CYC);

        // asynchronous reset mid-frame
        run_cycles(6);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_seg7", {8'd0, seg7}, 16'h0000);
        check("midrst_sel", {12'd0, seg7_sel}, 16'h0000);
        check("midrst_grant", {14'd0, grant}, 16'h0000);
        run_cycles(2);
        rst_n = 1'b1;

        for (int k = 0; k < 300; k++) begin
            req     = 2'($urandom_range(0, 3));
            digits0 = rand_digits();
            digits1 = rand_digits();
            run_cycles($urandom_range(1, 40));
        end

        run_cycles(2);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
